alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Upstream command buffer and downstream result collector for the 3-bit ALU stage.
- Accepts {a, b, select} operation requests over a valid/ready handshake and queues them in a FIFO. Each request is issued to the ALU, and the one ALU output that matches the request's select is captured.
- The captured result is presented as a single zero-extended 6-bit word on an output valid/ready handshake.
- The ALU itself is outside this block. The block drives its operands and select, and reads its four result buses combinationally.

Parameters:
- DEPTH, 4, number of FIFO entries. Must be a power of 2 and at least 2.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a request is present.
- in_ready  output  1  the FIFO can accept a request.
- in_a  input  3  operand a.
- in_b  input  3  operand b.
- in_sel  input  2  operation select: 00 sum, 01 invert_sum, 10 sub, 11 mul.
- alu_a  output  3  operand a to the ALU, taken from the FIFO head.
- alu_b  output  3  operand b to the ALU, taken from the FIFO head.
- alu_sel  output  2  select to the ALU, taken from the FIFO head.
- alu_sum  input  4  ALU sum result.
- alu_inv  input  4  ALU invert_sum result.
- alu_sub  input  3  ALU sub result.
- alu_mul  input  6  ALU mul result.
- out_valid  output  1  out_result holds a valid result.
- out_ready  input  1  the consumer accepts the result.
- out_result  output  6  captured result, zero-extended.
- out_sel  output  2  select of the op that produced out_result.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- ops_done  output  CNT_W  number of completed output handshakes.

Behaviour:
- Reset (asynchronous, takes effect immediately, holds while rst_n=0):
  - FIFO empties and its pointers go to 0; fifo_count=0.
  - out_valid=0, out_result=0, out_sel=0, ops_done=0.
  - in_ready=1 once reset is released.
  - Any op in flight is discarded; nothing is replayed.
- Push: when in_valid && in_ready at a clock edge, {in_a, in_b, in_sel} is written at the write pointer. Pointers wrap modulo DEPTH.
- in_ready = (fifo_count < DEPTH). It is registered-state based, with no combinational path from out_ready or from a same-cycle pop.
  - When the FIFO is full, in_ready=0 even if a pop occurs in the same cycle.
- ALU drive:
  - FIFO non-empty: alu_a, alu_b, alu_sel are driven combinationally from the head entry.
  - FIFO empty: alu_a, alu_b, alu_sel are all 0.
- The output register has two states:
  - OUT_EMPTY (out_valid=0).
  - OUT_FULL (out_valid=1).
- Pop condition: FIFO non-empty && (OUT_EMPTY || out_ready). On pop:
  - The head entry is removed.
  - out_sel <= head sel.
  - out_result <= selected ALU value:
    - 00: {2'b0, alu_sum}
    - 01: {2'b0, alu_inv}
    - 10: {3'b0, alu_sub}
    - 11: alu_mul
  - State becomes OUT_FULL.
- OUT_FULL && out_ready && no pop: state becomes OUT_EMPTY and out_valid drops. out_result and out_sel hold their last values.
- While out_valid=1 && out_ready=0, out_result and out_sel are stable.
- Simultaneous push and pop: fifo_count is unchanged and both pointers advance.
- Push into an empty FIFO: the request is not bypassed. The earliest pop is on the next edge.
- Latency: a request accepted at edge N into an idle block produces out_valid=1 after edge N+1.
- Throughput: 1 result per cycle when out_ready is held high.
- ops_done increments by 1 on every out_valid && out_ready edge and wraps from 2^CNT_W-1 to 0.
- Arithmetic: the block does no arithmetic on operands. It only selects and zero-extends ALU results.

Test Plan:
- Reset and single ops: after reset, check in_ready=1, out_valid=0, ops_done=0, fifo_count=0. The bench ALU model returns sum=a+b, sub=(a-b) mod 8, mul=a*b, inv=4'b0100.
  - Push a=3, b=7, sel=00 → out_valid one edge after acceptance, out_result=6'b001010, out_sel=00.
- All selects: push a=3, b=7 with sel 01, 10, 11 back-to-back, out_ready=1 → results 6'b000100, 6'b000100, 6'b010101 in order on consecutive cycles, ops_done=3.
- Backpressure/full: hold out_ready=0 and push 5 requests → 1 moves to the output register, then 4 fill the FIFO. Check fifo_count=4, in_ready=0, out_result stable.
  - Release out_ready → the 5 results drain in order with no loss or duplication.
- Simultaneous push/pop at full: while draining, assert in_valid continuously → no push while in_ready=0. A push is accepted the cycle after the first pop, and fifo_count stays consistent.
- Reset mid-operation: with 3 entries queued and out_valid=1, pulse rst_n low between clock edges → outputs clear immediately with no clock, nothing is emitted after release, and ops_done=0.
- Counter wrap: with CNT_W=2, complete 5 handshakes → ops_done sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Request queue and result collector around an external 3-bit ALU.
// Requests {a, b, sel} are buffered in a FIFO, the head entry drives the ALU,
// and the ALU output matching the head's select is captured into a
// valid/ready output register.
module alu_op_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_a,
    input  logic [2:0]                 in_b,
    input  logic [1:0]                 in_sel,
    output logic [2:0]                 alu_a,
    output logic [2:0]                 alu_b,
    output logic [1:0]                 alu_sel,
    input  logic [3:0]                 alu_sum,
    input  logic [3:0]                 alu_inv,
    input  logic [2:0]                 alu_sub,
    input  logic [5:0]                 alu_mul,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [5:0]                 out_result,
    output logic [1:0]                 out_sel,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [CNT_W-1:0]           ops_done
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_FW = PTR_W + 1;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] sel;
    } req_t;

    typedef enum logic [0:0] {
        OutEmpty,
        OutFull
    } out_state_e;

    req_t              mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_FW-1:0] count_q;
    out_state_e        state_q;

    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       out_hs;
    req_t       head;
    req_t       in_req;
    logic [5:0] sel_result;

    // Readiness depends only on registered occupancy, never on a same-cycle pop.
    assign fifo_empty = (count_q == '0);
    assign in_ready   = (count_q < CNT_FW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = !fifo_empty && ((state_q == OutEmpty) || out_ready);
    assign out_hs     = (state_q == OutFull) && out_ready;
    assign head       = mem_q[rd_ptr_q];
    assign in_req     = '{a: in_a, b: in_b, sel: in_sel};
    assign fifo_count = count_q;
    assign out_valid  = (state_q == OutFull);

    // Present the head entry to the ALU; zeros while the queue is empty.
    always_comb begin
        alu_a   = 3'd0;
        alu_b   = 3'd0;
        alu_sel = 2'd0;
        if (!fifo_empty) begin
            alu_a   = head.a;
            alu_b   = head.b;
            alu_sel = head.sel;
        end
    end

    // Pick the ALU bus named by the head select and zero-extend it.
    always_comb begin
        sel_result = 6'd0;
        unique case (head.sel)
            2'b00: sel_result = {2'b00, alu_sum};
            2'b01: sel_result = {2'b00, alu_inv};
            2'b10: sel_result = {3'b000, alu_sub};
            2'b11: sel_result = alu_mul;
            default: sel_result = 6'd0;
        endcase
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_req;
        end
    end

    // FIFO pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_FW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_FW'(1);
            end
        end
    end

    // Output register FSM with captured result, select and handshake counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OutEmpty;
            out_result <= 6'd0;
            out_sel    <= 2'd0;
            ops_done   <= '0;
        end else begin
            if (out_hs) begin
                ops_done <= ops_done + CNT_W'(1);
            end
            case (state_q)
                OutEmpty: begin
                    if (pop) begin
                        out_result <= sel_result;
                        out_sel    <= head.sel;
                        state_q    <= OutFull;
                    end
                end
                OutFull: begin
                    if (pop) begin
                        out_result <= sel_result;
                        out_sel    <= head.sel;
                    end else if (out_ready) begin
                        // Result and select hold their last values after the drop.
                        state_q <= OutEmpty;
                    end
                end
                default: state_q <= OutEmpty;
            endcase
        end
    end

endmodule
